// File: rtl/tester_pkg.sv
// Shared constants and types for the SRAM tester statistics/display back-end.
// Segment glyphs are active low, bit0 = segment a ... bit6 = segment g.
package tester_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;

    typedef logic [3:0] bcd_digit_t;

    typedef enum logic [1:0] {
        DIG_UNITS     = 2'd0,
        DIG_TENS      = 2'd1,
        DIG_HUNDREDS  = 2'd2,
        DIG_THOUSANDS = 2'd3
    } dig_idx_e;

endpackage

// File: rtl/bcd_to_7seg.sv
// Combinational BCD to active-low 7-segment decoder with a blank override.
// Non-decimal codes never occur in a BCD counter; they decode to blank.
module bcd_to_7seg
    import tester_pkg::*;
(
    input  bcd_digit_t  bcd_i,
    input  logic        blank_i,
    output logic [6:0]  seg_n_o
);

    always_comb begin
        seg_n_o = SEG_BLANK;
        if (!blank_i) begin
            case (bcd_i)
                4'd0:    seg_n_o = SEG_0;
                4'd1:    seg_n_o = SEG_1;
                4'd2:    seg_n_o = SEG_2;
                4'd3:    seg_n_o = SEG_3;
                4'd4:    seg_n_o = SEG_4;
                4'd5:    seg_n_o = SEG_5;
                4'd6:    seg_n_o = SEG_6;
                4'd7:    seg_n_o = SEG_7;
                4'd8:    seg_n_o = SEG_8;
                4'd9:    seg_n_o = SEG_9;
                default: seg_n_o = SEG_BLANK;
            endcase
        end
    end

endmodule

// File: rtl/tester_stats.sv
// Pass/error statistics for the SRAM tester: 4-digit BCD pass counter on a
// multiplexed 7-segment display, saturating error counter on binary LEDs.
module tester_stats
    import tester_pkg::*;
#(
    parameter int SCAN_BITS  = 16,
    parameter int LEAD_BLANK = 1,
    parameter int ERR_W      = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc_pass_ctr,
    input  logic             inc_err_ctr,
    input  logic             clr,
    output logic [15:0]      pass_bcd,
    output logic             pass_wrap,
    output logic [ERR_W-1:0] err_leds,
    output logic             err_sat,
    output logic [6:0]       seg_n,
    output logic [3:0]       dig_n
);

    localparam logic [ERR_W-1:0] ERR_MAX = '1;

    logic                 pass_q;
    logic                 inc;
    bcd_digit_t [3:0]     bcd_q, bcd_d;
    logic                 carry;
    logic                 wrap_q, wrap_d;
    logic [ERR_W-1:0]     err_q, err_d;
    logic                 sat_q, sat_d;

    logic [SCAN_BITS-1:0] presc_q, presc_d;
    logic                 tc;
    dig_idx_e             idx_q, idx_d;
    logic                 armed_q, armed_d;
    logic [3:0]           lead_zero;
    bcd_digit_t           sel_digit;
    logic                 show;
    logic [6:0]           seg_dec;
    logic [6:0]           seg_n_q;
    logic [3:0]           dig_n_d, dig_n_q;

    assign inc = inc_pass_ctr & ~pass_q;

    // Ripple the carry from units upward; a carry out of thousands is the wrap.
    always_comb begin
        bcd_d = bcd_q;
        carry = inc;
        for (int i = 0; i < 4; i++) begin
            if (carry) begin
                if (bcd_q[i] == 4'd9) begin
                    bcd_d[i] = 4'd0;
                end else begin
                    bcd_d[i] = bcd_q[i] + 4'd1;
                    carry    = 1'b0;
                end
            end
        end
        wrap_d = carry;
        if (clr) begin
            bcd_d  = '0;
            wrap_d = 1'b0;
        end
    end

    always_comb begin
        err_d = err_q;
        if (clr) begin
            err_d = '0;
        end else if (inc_err_ctr && (err_q != ERR_MAX)) begin
            err_d = err_q + 1'b1;
        end
        sat_d = (err_d == ERR_MAX);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pass_q <= 1'b0;
            bcd_q  <= '0;
            wrap_q <= 1'b0;
            err_q  <= '0;
            sat_q  <= 1'b0;
        end else begin
            pass_q <= inc_pass_ctr;
            bcd_q  <= bcd_d;
            wrap_q <= wrap_d;
            err_q  <= err_d;
            sat_q  <= sat_d;
        end
    end

    // Scan FSM: state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q <= '0;
            idx_q   <= DIG_UNITS;
            armed_q <= 1'b0;
        end else begin
            presc_q <= presc_d;
            idx_q   <= idx_d;
            armed_q <= armed_d;
        end
    end

    // Scan FSM: next state. armed holds the display dark until the first full period.
    always_comb begin
        tc      = &presc_q;
        presc_d = presc_q + 1'b1;
        idx_d   = tc ? dig_idx_e'(idx_q + 2'd1) : idx_q;
        armed_d = armed_q | tc;
    end

    // Scan FSM: outputs. Terminal count forces an all-off gap against ghosting.
    always_comb begin
        lead_zero[3] = (bcd_q[3] == 4'd0);
        lead_zero[2] = lead_zero[3] & (bcd_q[2] == 4'd0);
        lead_zero[1] = lead_zero[2] & (bcd_q[1] == 4'd0);
        lead_zero[0] = lead_zero[1] & (bcd_q[0] == 4'd0);
        sel_digit    = bcd_q[idx_q];
        show         = armed_q & ~tc &
                       ~((LEAD_BLANK != 0) && (idx_q != DIG_UNITS) && lead_zero[idx_q]);
        dig_n_d      = show ? ~(4'b0001 << idx_q) : 4'hF;
    end

    bcd_to_7seg u_dec (
        .bcd_i   (sel_digit),
        .blank_i (~show),
        .seg_n_o (seg_dec)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_n_q <= SEG_BLANK;
            dig_n_q <= 4'hF;
        end else begin
            seg_n_q <= seg_dec;
            dig_n_q <= dig_n_d;
        end
    end

    assign pass_bcd  = bcd_q;
    assign pass_wrap = wrap_q;
    assign err_leds  = err_q;
    assign err_sat   = sat_q;
    assign seg_n     = seg_n_q;
    assign dig_n     = dig_n_q;

endmodule

// File: tb/tb_tester_stats.sv
// Bench for tester_stats: vector table, directed corner sequences and random
// stimulus, all checked against a count-level reference model.
module tb_tester_stats;

    localparam int SCAN_BITS  = 2;
    localparam int LEAD_BLANK = 1;
    localparam int ERR_W      = 10;
    localparam int P          = 1 << SCAN_BITS;
    localparam int ERR_MAX    = (1 << ERR_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic             inc_pass_ctr = 1'b0;
    logic             inc_err_ctr = 1'b0;
    logic             clr = 1'b0;
    logic [15:0]      pass_bcd;
    logic             pass_wrap;
    logic [ERR_W-1:0] err_leds;
    logic             err_sat;
    logic [6:0]       seg_n;
    logic [3:0]       dig_n;

    always #5 clk = ~clk;

    tester_stats #(
        .SCAN_BITS  (SCAN_BITS),
        .LEAD_BLANK (LEAD_BLANK),
        .ERR_W      (ERR_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .inc_pass_ctr (inc_pass_ctr),
        .inc_err_ctr  (inc_err_ctr),
        .clr          (clr),
        .pass_bcd     (pass_bcd),
        .pass_wrap    (pass_wrap),
        .err_leds     (err_leds),
        .err_sat      (err_sat),
        .seg_n        (seg_n),
        .dig_n        (dig_n)
    );

    int passed = 0;
    int total  = 0;

    // Reference model state: plain integers for the counts, edge count for the scan.
    int         m_count;
    int         m_err;
    int         m_k;
    bit         m_prev;
    bit         m_wrap;
    int         dig_seen[4];
    int         p10[4];
    logic [6:0] glyph[10];

    typedef struct {
        bit          p;
        bit          e;
        bit          c;
        logic [15:0] bcd;
        int          err;
    } vec_t;
    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [15:0] to_bcd(input int n);
        return {4'(n / 1000 % 10), 4'(n / 100 % 10), 4'(n / 10 % 10), 4'(n % 10)};
    endfunction

    task automatic step();
        int         ki, presc, idx, d;
        bit         inc, show;
        logic [3:0] edig;
        logic [6:0] eseg;
        @(posedge clk);
        ki    = m_k;
        m_k++;
        presc = ki % P;
        idx   = (ki / P) % 4;
        d     = (m_count / p10[idx]) % 10;
        show  = (ki >= P) && (presc != P - 1) &&
                !((LEAD_BLANK != 0) && (idx != 0) && (m_count < p10[idx]));
        edig  = show ? ~(4'b0001 << idx) : 4'hF;
        eseg  = show ? glyph[d] : 7'h7F;
        inc    = inc_pass_ctr && !m_prev;
        m_prev = inc_pass_ctr;
        m_wrap = 1'b0;
        if (clr) m_count = 0;
        else if (inc) begin
            if (m_count == 9999) begin
                m_count = 0;
                m_wrap  = 1'b1;
            end else begin
                m_count++;
            end
        end
        if (clr) m_err = 0;
        else if (inc_err_ctr && m_err < ERR_MAX) m_err++;
        #1;
        check("pass_bcd", 32'(pass_bcd), 32'(to_bcd(m_count)));
        check("pass_wrap", 32'(pass_wrap), 32'(m_wrap));
        check("err_leds", 32'(err_leds), 32'(m_err));
        check("err_sat", 32'(err_sat), 32'(m_err == ERR_MAX));
        check("dig_n", 32'(dig_n), 32'(edig));
        check("seg_n", 32'(seg_n), 32'(eseg));
        if (show) dig_seen[idx]++;
    endtask

    task automatic do_reset();
        inc_pass_ctr = 1'b0;
        inc_err_ctr  = 1'b0;
        clr          = 1'b0;
        rst_n        = 1'b0;
        #1;
        check("rst_pass_bcd", 32'(pass_bcd), 32'h0);
        check("rst_pass_wrap", 32'(pass_wrap), 32'h0);
        check("rst_err_leds", 32'(err_leds), 32'h0);
        check("rst_err_sat", 32'(err_sat), 32'h0);
        check("rst_seg_n", 32'(seg_n), 32'h7F);
        check("rst_dig_n", 32'(dig_n), 32'hF);
        m_count = 0;
        m_err   = 0;
        m_prev  = 1'b0;
        m_wrap  = 1'b0;
        m_k     = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic pulse();
        inc_pass_ctr = 1'b1;
        step();
        inc_pass_ctr = 1'b0;
        step();
    endtask

    task automatic clear_seen();
        for (int i = 0; i < 4; i++) dig_seen[i] = 0;
    endtask

    initial begin
        int wrap_cnt;
        glyph = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
        p10   = '{1, 10, 100, 1000};
        vecs[0] = '{1'b1, 1'b0, 1'b0, 16'h0001, 0};
        vecs[1] = '{1'b1, 1'b1, 1'b0, 16'h0001, 1};
        vecs[2] = '{1'b0, 1'b1, 1'b0, 16'h0001, 2};
        vecs[3] = '{1'b1, 1'b0, 1'b0, 16'h0002, 2};
        vecs[4] = '{1'b0, 1'b0, 1'b1, 16'h0000, 0};
        vecs[5] = '{1'b1, 1'b1, 1'b1, 16'h0000, 0};
        vecs[6] = '{1'b1, 1'b0, 1'b0, 16'h0000, 0};
        vecs[7] = '{1'b0, 1'b0, 1'b0, 16'h0000, 0};
        vecs[8] = '{1'b1, 1'b1, 1'b0, 16'h0001, 1};
        vecs[9] = '{1'b0, 1'b0, 1'b0, 16'h0001, 1};

        #2;
        do_reset();

        // Vector table from reset.
        for (int i = 0; i < 10; i++) begin
            inc_pass_ctr = vecs[i].p;
            inc_err_ctr  = vecs[i].e;
            clr          = vecs[i].c;
            step();
            check("vec_bcd", 32'(pass_bcd), 32'(vecs[i].bcd));
            check("vec_err", 32'(err_leds), 32'(vecs[i].err));
            check("vec_wrap", 32'(pass_wrap), 32'h0);
        end
        clr = 1'b0;

        // Single pulse: only the units digit may ever light.
        do_reset();
        clear_seen();
        pulse();
        check("one_pulse_bcd", 32'(pass_bcd), 32'h0001);
        repeat (40) step();
        check("one_units_lit", 32'(dig_seen[0] > 0), 32'h1);
        for (int i = 1; i < 4; i++) check("one_upper_dark", 32'(dig_seen[i]), 32'h0);

        // Held strobe counts once.
        do_reset();
        inc_pass_ctr = 1'b1;
        repeat (50) step();
        inc_pass_ctr = 1'b0;
        step();
        check("hold_bcd", 32'(pass_bcd), 32'h0001);

        // Error counter saturation.
        do_reset();
        inc_err_ctr = 1'b1;
        repeat (1030) step();
        inc_err_ctr = 1'b0;
        step();
        check("sat_leds", 32'(err_leds), 32'h3FF);
        check("sat_flag", 32'(err_sat), 32'h1);

        // clr on the same edge as a pass rising edge and an error.
        pulse();
        inc_pass_ctr = 1'b1;
        inc_err_ctr  = 1'b1;
        clr          = 1'b1;
        step();
        check("clr_bcd", 32'(pass_bcd), 32'h0);
        check("clr_err", 32'(err_leds), 32'h0);
        check("clr_wrap", 32'(pass_wrap), 32'h0);
        check("clr_sat", 32'(err_sat), 32'h0);
        inc_pass_ctr = 1'b0;
        inc_err_ctr  = 1'b0;
        clr          = 1'b0;
        step();

        // 0305 on the display: thousands blanked, other digits scanned.
        do_reset();
        repeat (305) pulse();
        check("scan_bcd", 32'(pass_bcd), 32'h0305);
        clear_seen();
        repeat (64) step();
        for (int i = 0; i < 3; i++) check("scan_digit_lit", 32'(dig_seen[i] > 0), 32'h1);
        check("scan_thousands_dark", 32'(dig_seen[3]), 32'h0);

        // Run up to 9999 then wrap.
        repeat (9999 - 305) pulse();
        check("pre_wrap_bcd", 32'(pass_bcd), 32'h9999);
        wrap_cnt = 0;
        inc_pass_ctr = 1'b1;
        step();
        if (pass_wrap) wrap_cnt++;
        inc_pass_ctr = 1'b0;
        repeat (4) begin
            step();
            if (pass_wrap) wrap_cnt++;
        end
        check("wrap_bcd", 32'(pass_bcd), 32'h0);
        check("wrap_pulses", 32'(wrap_cnt), 32'h1);

        // Random stimulus against the model.
        repeat (3000) begin
            inc_pass_ctr = 1'($urandom_range(0, 1));
            inc_err_ctr  = 1'($urandom_range(0, 3) == 0);
            clr          = 1'($urandom_range(0, 60) == 0);
            step();
        end
        clr = 1'b0;
        inc_pass_ctr = 1'b0;
        inc_err_ctr  = 1'b0;

        // Asynchronous reset in the middle of a scan.
        repeat (305) pulse();
        repeat (6) step();
        rst_n = 1'b0;
        #1;
        check("async_dig_n", 32'(dig_n), 32'hF);
        check("async_seg_n", 32'(seg_n), 32'h7F);
        check("async_bcd", 32'(pass_bcd), 32'h0);
        do_reset();
        repeat (2 * P + 4) step();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
